// File: rtl/led_cube_uart_pkg.sv
// Shared constants and FSM state type for the LED cube UART transmit master.
// Build option: LED_CUBE_TX_BACKOFF_EN adds a 16-cycle BACKOFF state after a TRDY=0 poll.
package led_cube_uart_pkg;

   localparam logic [4:0] UART_RXDATA  = 5'd0;
   localparam logic [4:0] UART_TXDATA  = 5'd4;
   localparam logic [4:0] UART_STATUS  = 5'd8;
   localparam logic [4:0] UART_CONTROL = 5'd12;

   localparam int TRDY_BIT = 6;
   localparam int TMT_BIT  = 5;

   localparam logic [3:0] BACKOFF_LOAD = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL,
      ST_RDWAIT,
      ST_WRITE
`ifdef LED_CUBE_TX_BACKOFF_EN
      , ST_BACKOFF
`endif
   } tx_state_t;

endpackage

// File: rtl/led_cube_uart_tx_if.sv
// Avalon-MM bus between the transmit master and the UART slave port.
interface led_cube_uart_tx_if;
   logic [4:0]  address;
   logic        read;
   logic [15:0] readdata;
   logic        readdatavalid;
   logic        write;
   logic [15:0] writedata;
   logic        waitrequest;

   modport master (
      output address, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/led_cube_byte_fifo.sv
// Circular byte FIFO with wrapping pointers and an explicit occupancy count.
module led_cube_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/led_cube_uart_tx.sv
// UART transmit master: buffers cube bytes, polls STATUS.TRDY, then writes TXDATA.
// Build option: LED_CUBE_TX_BACKOFF_EN inserts a 16-cycle BACKOFF before re-polling.
module led_cube_uart_tx
   import led_cube_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          byte_valid,
   input  logic [7:0]                    byte_data,
   output logic                          byte_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_busy,
   led_cube_uart_tx_if.master            avalon_master
);

   tx_state_t  state, state_n;
   logic       push, pop, fifo_full, fifo_empty;
   logic [7:0] head_data;
   logic       unused_rd;

`ifdef LED_CUBE_TX_BACKOFF_EN
   logic [3:0] bo_cnt, bo_cnt_n;
`endif

   assign push       = byte_valid & byte_ready;
   assign pop        = (state == ST_WRITE) & ~avalon_master.waitrequest;
   assign byte_ready = ~fifo_full;
   assign tx_busy    = (state != ST_IDLE);
   assign unused_rd  = ^{avalon_master.readdata[15:7], avalon_master.readdata[5:0]};

   led_cube_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (byte_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

`ifdef LED_CUBE_TX_BACKOFF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) bo_cnt <= '0;
      else        bo_cnt <= bo_cnt_n;
   end
`endif

   always_comb begin
      state_n = state;
`ifdef LED_CUBE_TX_BACKOFF_EN
      bo_cnt_n = bo_cnt;
`endif
      unique case (state)
         // A push this cycle starts the poll without waiting for the count to update.
         ST_IDLE:   if (!fifo_empty || push) state_n = ST_POLL;
         ST_POLL:   if (!avalon_master.waitrequest) state_n = ST_RDWAIT;
         ST_RDWAIT: begin
            if (avalon_master.readdatavalid) begin
               if (avalon_master.readdata[TRDY_BIT]) begin
                  state_n = ST_WRITE;
               end else begin
`ifdef LED_CUBE_TX_BACKOFF_EN
                  state_n  = ST_BACKOFF;
                  bo_cnt_n = BACKOFF_LOAD;
`else
                  state_n = ST_POLL;
`endif
               end
            end
         end
         ST_WRITE:  if (!avalon_master.waitrequest) state_n = ST_IDLE;
`ifdef LED_CUBE_TX_BACKOFF_EN
         ST_BACKOFF: begin
            if (bo_cnt == '0) state_n = ST_POLL;
            else              bo_cnt_n = bo_cnt - 4'd1;
         end
`endif
         default:   state_n = ST_IDLE;
      endcase
   end

   // Bus outputs are pure decodes of the state register.
   always_comb begin
      avalon_master.read      = (state == ST_POLL);
      avalon_master.write     = (state == ST_WRITE);
      avalon_master.address   = '0;
      avalon_master.writedata = '0;
      if (state == ST_POLL) begin
         avalon_master.address = UART_STATUS;
      end else if (state == ST_WRITE) begin
         avalon_master.address   = UART_TXDATA;
         avalon_master.writedata = {8'h00, head_data};
      end
   end

endmodule

// File: tb/tb_led_cube_uart_tx.sv
// Bench for led_cube_uart_tx: behavioural UART slave plus a byte scoreboard.
module tb_led_cube_uart_tx;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_ready;
   logic [3:0] fifo_count;
   logic       tx_busy;

   led_cube_uart_tx_if avm();

   led_cube_uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .fifo_count    (fifo_count),
      .tx_busy       (tx_busy),
      .avalon_master (avm)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // slave model knobs and scoreboard
   logic        stall = 1'b0;
   int          wr_stall_cfg = 0;
   int          wr_used = 0;
   int          rd_lat = 1;
   int          pend_rd = 0;
   logic [15:0] status_q[$];
   logic [7:0]  sb[$];
   int          n_rd = 0, n_wr = 0, wr_cycles = 0;
   logic        polled = 1'b0;
   logic [20:0] wr_first;
   logic [7:0]  exp_b;

   always_comb avm.waitrequest = stall || (avm.write && (wr_used < wr_stall_cfg));

   always @(posedge clk) begin
      if (avm.write && avm.waitrequest) wr_used <= wr_used + 1;
      else if (!avm.write)              wr_used <= 0;
   end

   initial begin
      avm.readdatavalid = 1'b0;
      avm.readdata      = 16'h0000;
      forever begin
         @(negedge clk);
         #1;
         avm.readdatavalid = 1'b0;
         if (pend_rd != 0) begin
            pend_rd--;
            if (pend_rd == 0) begin
               avm.readdatavalid = 1'b1;
               avm.readdata = (status_q.size() != 0) ? status_q.pop_front() : 16'h0040;
            end
         end
         if (rst_n) begin
            if (avm.read || avm.write) chk("rd_wr_excl", 32'(avm.read & avm.write), 0);
            if (avm.read && !avm.waitrequest) begin
               n_rd++;
               polled  = 1'b1;
               pend_rd = rd_lat;
               chk("rd_addr", 32'(avm.address), 8);
            end
            if (avm.write) begin
               if (wr_cycles == 0) wr_first = {avm.address, avm.writedata};
               else chk("wr_stable", 32'({avm.address, avm.writedata}), 32'(wr_first));
               wr_cycles++;
               if (!avm.waitrequest) begin
                  n_wr++;
                  chk("wr_addr", 32'(avm.address), 4);
                  chk("poll_before_wr", 32'(polled), 1);
                  chk("wr_cycles", wr_cycles, wr_stall_cfg + 1);
                  polled    = 1'b0;
                  wr_cycles = 0;
                  if (sb.size() == 0) chk("wr_unexpected", 1, 0);
                  else begin
                     exp_b = sb.pop_front();
                     chk("wr_data", 32'(avm.writedata), 32'({8'h00, exp_b}));
                  end
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!byte_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) chk("push_timeout", 0, 1);
      else begin
         byte_valid = 1'b1;
         byte_data  = d;
         sb.push_back(d);
         @(negedge clk);
         byte_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(fifo_count == 0 && !tx_busy) && t < 3000);
      chk("drain", 32'(fifo_count == 0 && !tx_busy), 1);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic chk_reset_outs(input string pfx);
      chk({pfx, "_read"},   32'(avm.read), 0);
      chk({pfx, "_write"},  32'(avm.write), 0);
      chk({pfx, "_addr"},   32'(avm.address), 0);
      chk({pfx, "_wdata"},  32'(avm.writedata), 0);
      chk({pfx, "_ready"},  32'(byte_ready), 1);
      chk({pfx, "_count"},  32'(fifo_count), 0);
      chk({pfx, "_busy"},   32'(tx_busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int r0, w0, t;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst_n = 1'b1;

      // single byte, TRDY ready immediately; POLL must follow the push directly
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      sb.push_back(8'hA5);
      @(negedge clk);
      byte_valid = 1'b0;
      chk("poll_lat", 32'(avm.read), 1);
      wait_drain();
      chk("t1_rd", n_rd, 1);
      chk("t1_wr", n_wr, 1);
      chk("t1_cnt", 32'(fifo_count), 0);

      // TRDY=0 twice before ready
      status_q.push_back(16'h0000);
      status_q.push_back(16'h0020);
      r0 = n_rd; w0 = n_wr;
      push_byte(8'h3C);
      wait_drain();
      chk("t2_rd", n_rd - r0, 3);
      chk("t2_wr", n_wr - w0, 1);

      // fill past full with the slave stalled
      stall = 1'b1;
      for (int i = 0; i < 8; i++) push_byte(8'(i));
      chk("t3_ready", 32'(byte_ready), 0);
      chk("t3_cnt", 32'(fifo_count), 8);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'd8;
      repeat (4) begin
         @(negedge clk);
         chk("t3_hold_cnt", 32'(fifo_count), 8);
      end
      stall = 1'b0;
      t = 0;
      while (!byte_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("t3_ready_again", 32'(byte_ready), 1);
      sb.push_back(8'd8);
      @(negedge clk);
      byte_valid = 1'b0;
      wait_drain();

      // write stalled for 3 cycles
      wr_stall_cfg = 3;
      w0 = n_wr;
      push_byte(8'h77);
      wait_drain();
      chk("t4_wr", n_wr - w0, 1);
      chk("t4_cnt", 32'(fifo_count), 0);

      // push and pop in the same cycle at count 3
      wr_stall_cfg = 4;
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      t = 0;
      while (!(avm.write && !avm.waitrequest) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t5_cnt_pre", 32'(fifo_count), 3);
      byte_valid = 1'b1;
      byte_data  = 8'h44;
      sb.push_back(8'h44);
      @(negedge clk);
      byte_valid = 1'b0;
      chk("t5_cnt", 32'(fifo_count), 3);
      wait_drain();
      wr_stall_cfg = 0;

      // reset during RDWAIT; the late readdatavalid must not cause a write
      rd_lat = 3;
      push_byte(8'h99);
      t = 0;
      while (!(tx_busy && !avm.read && !avm.write) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t6_in_rdwait", 32'(tx_busy && !avm.read && !avm.write), 1);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk_reset_outs("t6");
      rst_n = 1'b1;
      w0 = n_wr;
      repeat (10) @(negedge clk);
      chk("t6_no_wr", n_wr - w0, 0);
      chk("t6_idle", 32'(tx_busy), 0);
      rd_lat = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
